// File: rtl/hazard_sequencer.sv
// Pipeline bubble controller: one prioritized FSM that sequences load-use stalls,
// taken-branch flushes and interrupt entry for the five-stage pipeline.
module hazard_sequencer #(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 3,
    parameter int INT_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_use,
    input  logic       branch_taken,
    input  logic       int_req,
    output logic       pc_write_en,
    output logic       ifid_write_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       fetch_nop,
    output logic       pc_sel_int,
    output logic       int_ack,
    output logic       busy,
    output logic [2:0] remain,
    output logic [1:0] fsm_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STALL  = 2'd1;
    localparam logic [1:0] FLUSH  = 2'd2;
    localparam logic [1:0] ST_INT = 2'd3;

    localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] INT_LOAD   = 3'(INT_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] state_nx;
    logic [2:0] cnt;
    logic [2:0] cnt_nx;
    logic       int_pending;
    logic       int_pending_nx;

    logic       int_wanted;
    logic [1:0] entry_state;
    logic [2:0] entry_cnt;

    // Interrupt handshake: int_req is a level held by the requester until it sees
    // int_ack (one cycle, last INT cycle); it must be low at the following edge,
    // otherwise that edge is taken as a fresh request.
    assign int_wanted = int_req | int_pending;

    // Selection used both from IDLE and when a sequence finishes (cnt == 0),
    // which is what makes back-to-back sequences gapless.
    always_comb begin
        entry_state = IDLE;
        entry_cnt   = 3'd0;
        if (branch_taken) begin
            entry_state = FLUSH;
            entry_cnt   = FLUSH_LOAD;
        end else if (int_wanted) begin
            entry_state = ST_INT;
            entry_cnt   = INT_LOAD;
        end else if (load_use) begin
            entry_state = STALL;
            entry_cnt   = STALL_LOAD;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                state_nx = entry_state;
                cnt_nx   = entry_cnt;
            end
            STALL, FLUSH: begin
                if (branch_taken) begin
                    state_nx = FLUSH;
                    cnt_nx   = FLUSH_LOAD;
                end else if (cnt != 3'd0) begin
                    cnt_nx = cnt - 3'd1;
                end else begin
                    state_nx = entry_state;
                    cnt_nx   = entry_cnt;
                end
            end
            ST_INT: begin
                // Mid-sequence requests are ignored: INT always runs to completion.
                if (cnt != 3'd0) begin
                    cnt_nx = cnt - 3'd1;
                end else begin
                    state_nx = entry_state;
                    cnt_nx   = entry_cnt;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 3'd0;
            end
        endcase
    end

    always_comb begin
        int_pending_nx = int_pending;
        if (state != ST_INT && state_nx == ST_INT) begin
            int_pending_nx = 1'b0;
        end else if (state == ST_INT && cnt == 3'd0 && state_nx == ST_INT) begin
            int_pending_nx = 1'b0;
        end else if ((state == STALL || state == FLUSH) && int_req) begin
            int_pending_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            int_pending <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            int_pending <= int_pending_nx;
        end
    end

    // Outputs depend only on registered state and cnt.
    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        fetch_nop     = 1'b0;
        pc_sel_int    = 1'b0;
        int_ack       = 1'b0;
        case (state)
            STALL: begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                idex_flush    = 1'b1;
            end
            FLUSH: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                fetch_nop  = 1'b1;
            end
            ST_INT: begin
                ifid_write_en = 1'b0;
                ifid_flush    = 1'b1;
                idex_flush    = 1'b1;
                fetch_nop     = 1'b1;
                pc_write_en   = (cnt == 3'd0);
                pc_sel_int    = (cnt == 3'd0);
                int_ack       = (cnt == 3'd0);
            end
            default: begin
                pc_write_en   = 1'b1;
                ifid_write_en = 1'b1;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign remain    = (state == IDLE) ? 3'd0 : cnt;
    assign fsm_state = state;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: two parameterizations driven in lockstep, directed
// scenarios followed by random traffic, checked against a sequence-level model.
module tb_hazard_sequencer;

    logic       clk;
    logic       reset;
    logic       load_use;
    logic       branch_taken;
    logic       int_req;

    logic       pc_write_en   [2];
    logic       ifid_write_en [2];
    logic       ifid_flush    [2];
    logic       idex_flush    [2];
    logic       fetch_nop     [2];
    logic       pc_sel_int    [2];
    logic       int_ack       [2];
    logic       busy          [2];
    logic [2:0] remain        [2];
    logic [1:0] fsm_state     [2];

    int vectors  = 0;
    int failures = 0;

    // Sequence lengths for each instance: {stall, flush, int}.
    int k_stall [2] = '{1, 3};
    int k_flush [2] = '{3, 3};
    int k_int   [2] = '{4, 2};

    hazard_sequencer u_dut0 (
        .clk(clk), .reset(reset), .load_use(load_use), .branch_taken(branch_taken),
        .int_req(int_req), .pc_write_en(pc_write_en[0]), .ifid_write_en(ifid_write_en[0]),
        .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]), .fetch_nop(fetch_nop[0]),
        .pc_sel_int(pc_sel_int[0]), .int_ack(int_ack[0]), .busy(busy[0]),
        .remain(remain[0]), .fsm_state(fsm_state[0])
    );

    hazard_sequencer #(.STALL_CYCLES(3), .FLUSH_CYCLES(3), .INT_CYCLES(2)) u_dut1 (
        .clk(clk), .reset(reset), .load_use(load_use), .branch_taken(branch_taken),
        .int_req(int_req), .pc_write_en(pc_write_en[1]), .ifid_write_en(ifid_write_en[1]),
        .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]), .fetch_nop(fetch_nop[1]),
        .pc_sel_int(pc_sel_int[1]), .int_ack(int_ack[1]), .busy(busy[1]),
        .remain(remain[1]), .fsm_state(fsm_state[1])
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a sequence kind plus the number of cycles it still occupies
    // (including the present one), and a latched interrupt request.
    typedef enum int { K_NONE, K_STALL, K_FLUSH, K_INT } kind_t;
    kind_t m_kind [2];
    int    m_left [2];
    bit    m_pend [2];

    logic [10:0] exp_q0 [$];
    logic [10:0] exp_q1 [$];

    function automatic logic [10:0] expect_vec(kind_t k, int left);
        bit last;
        logic [2:0] rem;
        last = (left == 1);
        rem  = (k == K_NONE) ? 3'd0 : 3'(left - 1);
        // {pc_we, ifid_we, ifid_flush, idex_flush, nop, sel_int, ack, busy, remain}
        case (k)
            K_STALL: return {8'b0001_0001, rem};
            K_FLUSH: return {8'b1111_1001, rem};
            K_INT:   return {last, 3'b011, 1'b1, last, last, 1'b1, rem};
            default: return {8'b1100_0000, rem};
        endcase
    endfunction

    task automatic model_edge(input int m, input bit b, input bit i, input bit l, input bit r);
        kind_t pick;
        int    pick_len;
        bit    finishing;
        kind_t old;
        if (r) begin
            m_kind[m] = K_NONE;
            m_left[m] = 0;
            m_pend[m] = 0;
            return;
        end
        if (b) begin
            pick = K_FLUSH; pick_len = k_flush[m];
        end else if (i || m_pend[m]) begin
            pick = K_INT;   pick_len = k_int[m];
        end else if (l) begin
            pick = K_STALL; pick_len = k_stall[m];
        end else begin
            pick = K_NONE;  pick_len = 0;
        end
        old = m_kind[m];
        finishing = (old == K_NONE) || (m_left[m] == 1);
        if ((old == K_STALL || old == K_FLUSH) && b) begin
            m_kind[m] = K_FLUSH;
            m_left[m] = k_flush[m];
        end else if (finishing) begin
            m_kind[m] = pick;
            m_left[m] = pick_len;
        end else begin
            m_left[m] = m_left[m] - 1;
        end
        if (finishing && pick == K_INT && !((old == K_STALL || old == K_FLUSH) && b))
            m_pend[m] = 0;
        else if ((old == K_STALL || old == K_FLUSH) && i)
            m_pend[m] = 1;
    endtask

    function automatic logic [10:0] observe(input int m);
        return {pc_write_en[m], ifid_write_en[m], ifid_flush[m], idex_flush[m],
                fetch_nop[m], pc_sel_int[m], int_ack[m], busy[m], remain[m]};
    endfunction

    // Driver: apply inputs, clock one edge, update the model, compare #1 later.
    task automatic step(input bit b, input bit i, input bit l, input bit r, input string tag);
        logic [10:0] exp0;
        logic [10:0] exp1;
        logic [10:0] obs0;
        logic [10:0] obs1;
        branch_taken = b;
        int_req      = i;
        load_use     = l;
        reset        = r;
        @(posedge clk);
        model_edge(0, b, i, l, r);
        model_edge(1, b, i, l, r);
        exp_q0.push_back(expect_vec(m_kind[0], m_left[0]));
        exp_q1.push_back(expect_vec(m_kind[1], m_left[1]));
        #1;
        exp0 = exp_q0.pop_front();
        exp1 = exp_q1.pop_front();
        obs0 = observe(0);
        obs1 = observe(1);
        vectors++;
        assert (obs0 === exp0) else begin
            failures++;
            $error("FAIL %s dut0 observed=%b expected=%b", tag, obs0, exp0);
        end
        vectors++;
        assert (obs1 === exp1) else begin
            failures++;
            $error("FAIL %s dut1 observed=%b expected=%b", tag, obs1, exp1);
        end
    endtask

    task automatic idle_steps(input int n, input string tag);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, tag);
    endtask

    initial begin
        bit irq;
        int hold;
        bit rb;
        bit rl;
        bit rr;
        branch_taken = 0;
        int_req      = 0;
        load_use     = 0;
        reset        = 1;
        for (int m = 0; m < 2; m++) begin
            m_kind[m] = K_NONE;
            m_left[m] = 0;
            m_pend[m] = 0;
        end

        step(0, 0, 0, 1, "reset");
        step(0, 0, 0, 1, "reset");
        idle_steps(2, "idle_after_reset");

        step(0, 0, 1, 0, "load_use");
        idle_steps(4, "load_use_tail");

        step(1, 0, 0, 0, "branch");
        idle_steps(4, "branch_tail");

        // Interrupt held until the acknowledge is seen on the default instance.
        step(0, 1, 0, 0, "int_entry");
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, "int_hold");
        idle_steps(3, "int_drop");

        step(1, 1, 1, 0, "simultaneous");
        for (int k = 0; k < 2; k++) step(0, 0, 0, 0, "flush_then_int");
        idle_steps(6, "pending_int");

        step(0, 0, 1, 0, "stall_preempt_a");
        step(1, 0, 0, 0, "stall_preempt_b");
        idle_steps(4, "stall_preempt_tail");

        step(0, 1, 0, 0, "reset_mid_int_a");
        step(0, 1, 0, 0, "reset_mid_int_b");
        step(0, 0, 0, 1, "reset_mid_int_c");
        idle_steps(5, "after_mid_reset");

        step(1, 0, 0, 0, "flush_restart_a");
        step(0, 0, 0, 0, "flush_restart_b");
        step(1, 0, 0, 0, "flush_restart_c");
        idle_steps(4, "flush_restart_tail");

        step(0, 1, 0, 0, "int_ignores_a");
        step(1, 1, 1, 0, "int_ignores_b");
        step(0, 0, 0, 0, "int_ignores_c");
        idle_steps(5, "int_ignores_tail");

        irq  = 0;
        hold = 0;
        for (int n = 0; n < 1500; n++) begin
            rb = ($urandom_range(0, 7) == 0);
            rl = ($urandom_range(0, 3) == 0);
            rr = ($urandom_range(0, 79) == 0);
            if (hold > 0) begin
                hold--;
                if (hold == 0) irq = 0;
            end else if ($urandom_range(0, 9) == 0) begin
                irq  = 1;
                hold = $urandom_range(1, 8);
            end
            step(rb, irq, rl, rr, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline bubble controller for the five-stage processor. It samples hazard and event requests from decode/execute and the interrupt line. It then drives the PC and IF/ID write enables, the IF/ID and ID/EX flush controls, and the fetch-NOP select for a precise number of cycles. It replaces ad-hoc edge-triggered NOP counting with one synchronous, prioritized FSM covering load-use stalls, taken-branch flushes and interrupt entry.

## Interface
Parameters:
- STALL_CYCLES, 1, bubble cycles for a load-use hazard (legal 1..8)
- FLUSH_CYCLES, 3, NOP cycles after a taken branch/jump (legal 1..8)
- INT_CYCLES, 4, cycles of the interrupt entry sequence (legal 2..8)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  reset, synchronous, active-high
- load_use  in  1  load-use hazard detected in decode (level)
- branch_taken  in  1  taken branch/jump resolved in execute (level, one cycle per event)
- int_req  in  1  interrupt request, level, held until int_ack
- pc_write_en  out  1  PC register load enable
- ifid_write_en  out  1  IF/ID register load enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_flush  out  1  clear ID/EX to NOP
- fetch_nop  out  1  fetch mux selects NOP instead of memory word
- pc_sel_int  out  1  PC mux selects interrupt vector
- int_ack  out  1  one-cycle acknowledge of int_req
- busy  out  1  state != IDLE
- remain  out  3  cycles left in current sequence after this one

## Operation
- States: IDLE, STALL, FLUSH, INT. 3-bit down-counter cnt; remain = cnt (0 in IDLE). int_pending flag.
- All outputs are registered or decoded from registered state only; no input-to-output combinational path.
- Reset: state=IDLE, cnt=0, int_pending=0.
- Reset outputs: pc_write_en=1, ifid_write_en=1, all other outputs 0.
- Output decode:
  - IDLE: pc_write_en=1, ifid_write_en=1, rest 0.
  - STALL: pc_write_en=0, ifid_write_en=0, idex_flush=1, rest 0.
  - FLUSH: pc_write_en=1, ifid_write_en=1, ifid_flush=1, idex_flush=1, fetch_nop=1.
  - INT: pc_write_en=0, ifid_flush=1, idex_flush=1, fetch_nop=1. On last cycle (cnt==0): pc_write_en=1, pc_sel_int=1, int_ack=1.
- Entry priority, evaluated at each edge in IDLE: branch_taken > int_req > load_use.
  - Branch: FLUSH, cnt=FLUSH_CYCLES-1.
  - Interrupt: INT, cnt=INT_CYCLES-1.
  - Load-use: STALL, cnt=STALL_CYCLES-1.
- In a non-IDLE state with cnt>0: cnt decrements each edge. With cnt==0: exit to the next state chosen by the IDLE priority rules. int_pending counts as int_req. Exit goes to IDLE only if nothing is requested.
- Preemption:
  - branch_taken in STALL: go to FLUSH immediately, cnt reloaded.
  - branch_taken in FLUSH: restart FLUSH, cnt reloaded.
  - branch_taken in INT: ignored.
- load_use in FLUSH or INT: ignored (offending instruction is being flushed).
- int_req in STALL/FLUSH sets int_pending. int_pending clears when INT is entered. INT always runs to completion. int_ack fires exactly once per INT sequence.

## Timing
- Request sampled at edge N. Controls are active in cycles N+1 .. N+K (K = STALL/FLUSH/INT_CYCLES). busy=1 exactly K cycles for an isolated event.
- int_ack and pc_sel_int assert only in cycle N+INT_CYCLES. int_req must drop by the following edge. If it is still high there, a new INT sequence starts.
- Back-to-back sequences have no IDLE cycle between them.
- Reset asserted mid-sequence forces IDLE at that edge. The pending interrupt is discarded, and no int_ack is issued.

## Test plan
- Reset, then load_use=1 for one cycle at edge 5 -> cycle 6: pc_write_en=0, ifid_write_en=0, idex_flush=1, busy=1, remain=0; cycle 7 back to IDLE values.
- branch_taken pulse at edge 10 -> fetch_nop=1, ifid_flush=1 for cycles 11-13, remain 2,1,0; IDLE at 14.
- int_req held from edge 20 -> INT cycles 21-24; int_ack=pc_sel_int=1 only in cycle 24; drop int_req at edge 25 -> IDLE.
- Simultaneous branch_taken, int_req, load_use at edge 30 -> FLUSH 31-33, then INT 34-37 with no gap, load_use never honoured.
- STALL_CYCLES=3, load_use at edge 40, branch_taken at edge 41 -> STALL in cycle 41 only, FLUSH 42-44.
- int_req at edge 50 under INT_CYCLES=4, reset at edge 52 -> IDLE from cycle 53, int_ack never asserted, all outputs at reset values.
